// File: rtl/game_move_arbiter.sv
// Match controller for the counter-game core: sequences ROUNDS games, arbitrates the
// shared control input between two players, scores each game and declares the winner.
module game_move_arbiter #(
   parameter int         LOAD_W    = 4,
   parameter int         ROUNDS    = 3,
   parameter int         COOL_CYC  = 2,
   parameter logic [1:0] IDLE_CTRL = 2'b00,
   localparam int        RW        = $clog2(ROUNDS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LOAD_W-1:0] seed,
   input  logic              p0_valid,
   input  logic [1:0]        p0_ctrl,
   output logic              p0_ready,
   input  logic              p1_valid,
   input  logic [1:0]        p1_ctrl,
   output logic              p1_ready,
   output logic              game_init,
   output logic [LOAD_W-1:0] game_load,
   output logic [1:0]        game_ctrl,
   input  logic              game_over,
   input  logic [1:0]        game_who,
   output logic [RW-1:0]     round_cnt,
   output logic [RW-1:0]     p0_wins,
   output logic [RW-1:0]     p1_wins,
   output logic              busy,
   output logic              match_done,
   output logic [1:0]        match_winner
);

   localparam int CW = $clog2(COOL_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_COOL,
      S_DONE
   } state_t;

   state_t            state;
   logic [LOAD_W-1:0] seed_q;
   logic [CW-1:0]     cool_cnt;
   logic              rr;        // 0: player 0 wins a tie, 1: player 1 wins a tie
   logic              grant_ok;
   logic              grant0;
   logic              grant1;

   // A game_over cycle carries no move: the game is finished and the control word is dropped.
   assign grant_ok = (state == S_PLAY) && !game_over;
   assign grant0   = grant_ok && p0_valid && (!p1_valid || !rr);
   assign grant1   = grant_ok && p1_valid && (!p0_valid ||  rr);

   assign p0_ready   = grant0;
   assign p1_ready   = grant1;
   assign game_init  = (state == S_IDLE) || (state == S_LOAD);
   assign busy       = (state != S_IDLE);
   assign match_done = (state == S_DONE);

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         seed_q       <= '0;
         game_load    <= '0;
         game_ctrl    <= IDLE_CTRL;
         rr           <= 1'b0;
         cool_cnt     <= '0;
         round_cnt    <= '0;
         p0_wins      <= '0;
         p1_wins      <= '0;
         match_winner <= 2'b00;
      end else begin
         game_ctrl <= IDLE_CTRL;
         case (state)
            S_IDLE: begin
               if (start) begin
                  seed_q       <= seed;
                  game_load    <= seed;
                  round_cnt    <= '0;
                  p0_wins      <= '0;
                  p1_wins      <= '0;
                  match_winner <= 2'b00;
                  state        <= S_LOAD;
               end
            end
            S_LOAD: begin
               rr    <= 1'b0;
               state <= S_PLAY;
            end
            S_PLAY: begin
               if (game_over) begin
                  if (round_cnt != RW'(ROUNDS)) round_cnt <= round_cnt + RW'(1);
                  if (game_who == 2'b10 && p0_wins != RW'(ROUNDS)) p0_wins <= p0_wins + RW'(1);
                  if (game_who == 2'b01 && p1_wins != RW'(ROUNDS)) p1_wins <= p1_wins + RW'(1);
                  cool_cnt <= '0;
                  state    <= S_COOL;
               end else if (grant0) begin
                  game_ctrl <= p0_ctrl;
                  rr        <= 1'b1;
               end else if (grant1) begin
                  game_ctrl <= p1_ctrl;
                  rr        <= 1'b0;
               end
            end
            S_COOL: begin
               if (cool_cnt == CW'(COOL_CYC - 1)) begin
                  if (round_cnt == RW'(ROUNDS)) begin
                     match_winner <= (p0_wins > p1_wins) ? 2'b10 :
                                     (p1_wins > p0_wins) ? 2'b01 : 2'b11;
                     state        <= S_DONE;
                  end else begin
                     // round_cnt already counts the finished game, so it indexes the next one.
                     game_load <= seed_q + LOAD_W'(round_cnt);
                     state     <= S_LOAD;
                  end
               end else begin
                  cool_cnt <= cool_cnt + CW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
